// File: rtl/dump_pkg.sv
// ---------------------------------------------------------------------------
// dump_pkg
// Shared types for the architectural register dump responder.
//   dump_state_t : walk state (IDLE, MAP, PRF, OUT)
//   dump_beat_t  : one response beat {areg, preg, data, last}
// Beat field widths follow the default processor configuration.
// ---------------------------------------------------------------------------
package dump_pkg;

  localparam int DUMP_ARCH_REGS = 32;
  localparam int DUMP_PHYS_REGS = 128;
  localparam int DUMP_DATA_W    = 32;
  localparam int DUMP_AREG_W    = $clog2(DUMP_ARCH_REGS);
  localparam int DUMP_PREG_W    = $clog2(DUMP_PHYS_REGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    PRF  = 2'd2,
    OUT  = 2'd3
  } dump_state_t;

  typedef struct packed {
    logic [DUMP_AREG_W-1:0] areg;
    logic [DUMP_PREG_W-1:0] preg;
    logic [DUMP_DATA_W-1:0] data;
    logic                   last;
  } dump_beat_t;

endpackage

// File: rtl/arch_reg_dump.sv
// ---------------------------------------------------------------------------
// arch_reg_dump
// Walks the committed rename map and the physical register file for a
// contiguous range of architectural registers and returns one beat per
// register over a valid/ready channel.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_start, req_count  : first architectural register, count (0 = all)
//   map_stable            : rename map / PRF not being redirected this cycle
//   map_rd_areg/map_rd_preg : rename map read port (same-cycle result)
//   prf_rd_addr/prf_rd_data : PRF read port (same-cycle result)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_areg/preg/data/last : response beat fields
//   busy                  : a dump is in progress
// ---------------------------------------------------------------------------
module arch_reg_dump
  import dump_pkg::*;
#(
  parameter int ARCH_REGS = DUMP_ARCH_REGS,
  parameter int PHYS_REGS = DUMP_PHYS_REGS,
  parameter int DATA_W    = DUMP_DATA_W,
  parameter int AREG_W    = $clog2(ARCH_REGS),
  parameter int PREG_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AREG_W-1:0] req_start,
  input  logic [AREG_W:0]   req_count,
  input  logic              map_stable,
  output logic [AREG_W-1:0] map_rd_areg,
  input  logic [PREG_W-1:0] map_rd_preg,
  output logic [PREG_W-1:0] prf_rd_addr,
  input  logic [DATA_W-1:0] prf_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [AREG_W-1:0] rsp_areg,
  output logic [PREG_W-1:0] rsp_preg,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
);

  localparam logic [AREG_W:0]   FULL_COUNT = (AREG_W+1)'(ARCH_REGS);
  localparam logic [AREG_W:0]   REMAIN_ONE = (AREG_W+1)'(1);
  localparam logic [AREG_W-1:0] AREG_ONE   = AREG_W'(1);
  localparam logic [AREG_W-1:0] AREG_ZERO  = AREG_W'(0);

  dump_state_t       state;
  dump_state_t       next_state;
  logic [AREG_W-1:0] cur;
  logic [AREG_W:0]   remain;
  logic [PREG_W-1:0] preg_q;
  dump_beat_t        beat;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. An unstable map in PRF forces a fresh map lookup,
  // since the mapping captured in MAP may no longer be valid.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = MAP;
        end else begin
          next_state = IDLE;
        end
      end
      MAP: begin
        if (map_stable) begin
          next_state = PRF;
        end else begin
          next_state = MAP;
        end
      end
      PRF: begin
        if (map_stable) begin
          next_state = OUT;
        end else begin
          next_state = MAP;
        end
      end
      OUT: begin
        if (rsp_ready) begin
          if (beat.last) begin
            next_state = IDLE;
          end else begin
            next_state = MAP;
          end
        end else begin
          next_state = OUT;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      OUT: begin
        rsp_valid = 1'b1;
      end
      MAP, PRF: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Walk datapath: current index, remaining count, captured mapping and
  // the held response beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur    <= AREG_ZERO;
      remain <= '0;
      preg_q <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur    <= req_start;
            remain <= (req_count == '0) ? FULL_COUNT : req_count;
          end
        end
        MAP: begin
          if (map_stable) begin
            preg_q <= map_rd_preg;
          end
        end
        PRF: begin
          if (map_stable) begin
            beat.areg <= cur;
            beat.preg <= preg_q;
            // x0 is hardwired zero regardless of what the PRF entry holds.
            beat.data <= (cur == AREG_ZERO) ? '0 : prf_rd_data;
            beat.last <= (remain == REMAIN_ONE);
          end
        end
        OUT: begin
          if (rsp_ready && !beat.last) begin
            // Natural AREG_W-bit overflow gives the wrap to x0.
            cur    <= cur + AREG_ONE;
            remain <= remain - REMAIN_ONE;
          end
        end
        default: begin
          cur <= cur;
        end
      endcase
    end
  end

  // Read indices come directly from registers, so outside MAP/PRF they
  // simply keep presenting the last index used.
  assign map_rd_areg = cur;
  assign prf_rd_addr = preg_q;

  assign rsp_areg = beat.areg;
  assign rsp_preg = beat.preg;
  assign rsp_data = beat.data;
  assign rsp_last = beat.last;

endmodule

// File: tb/tb_arch_reg_dump.sv
module tb_arch_reg_dump;

  typedef struct packed {
    logic [4:0]  areg;
    logic [6:0]  preg;
    logic [31:0] data;
    logic        last;
  } tb_beat_t;

  typedef struct {
    logic [4:0] start;
    logic [5:0] count;
    int         nbeats;
    logic [4:0] last_areg;
  } req_vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_start;
  logic [5:0]  req_count;
  logic        map_stable;
  logic [4:0]  map_rd_areg;
  logic [6:0]  map_rd_preg;
  logic [6:0]  prf_rd_addr;
  logic [31:0] prf_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_areg;
  logic [6:0]  rsp_preg;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;

  logic [6:0]  map_mem [32];
  logic [31:0] prf_mem [128];

  int vecs  = 0;
  int fails = 0;

  assign map_rd_preg = map_mem[map_rd_areg];
  assign prf_rd_data = prf_mem[prf_rd_addr];

  arch_reg_dump dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_start  (req_start),
    .req_count  (req_count),
    .map_stable (map_stable),
    .map_rd_areg(map_rd_areg),
    .map_rd_preg(map_rd_preg),
    .prf_rd_addr(prf_rd_addr),
    .prf_rd_data(prf_rd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_areg   (rsp_areg),
    .rsp_preg   (rsp_preg),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input tb_beat_t got, input tb_beat_t exp);
    chk({tag, ".areg"}, 32'(got.areg), 32'(exp.areg));
    chk({tag, ".preg"}, 32'(got.preg), 32'(exp.preg));
    chk({tag, ".data"}, got.data, exp.data);
    chk({tag, ".last"}, 32'(got.last), 32'(exp.last));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_areg"}, 32'(rsp_areg), 32'd0);
    chk({tag, ".rsp_preg"}, 32'(rsp_preg), 32'd0);
    chk({tag, ".rsp_data"}, rsp_data, 32'd0);
    chk({tag, ".rsp_last"}, 32'(rsp_last), 32'd0);
    chk({tag, ".map_rd_areg"}, 32'(map_rd_areg), 32'd0);
    chk({tag, ".prf_rd_addr"}, 32'(prf_rd_addr), 32'd0);
  endtask

  function automatic tb_beat_t model(input logic [4:0] a, input logic l);
    tb_beat_t m;
    m.areg = a;
    m.preg = map_mem[a];
    m.data = (a == 5'd0) ? 32'd0 : prf_mem[map_mem[a]];
    m.last = l;
    return m;
  endfunction

  // Drive a request at a falling edge; returns just after the accepting edge.
  task automatic send_req(input logic [4:0] s, input logic [5:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_start = s;
    req_count = c;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count falling edges until rsp_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 60);
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  // Wait for a beat, capture it and let the handshake edge pass.
  task automatic get_beat(output tb_beat_t b, output int cyc);
    wait_valid(cyc);
    b.areg = rsp_areg;
    b.preg = rsp_preg;
    b.data = rsp_data;
    b.last = rsp_last;
    @(posedge clk);
    #1;
  endtask

  tb_beat_t a01_exp  [2];
  tb_beat_t wrap_exp [4];
  req_vec_t vt       [5];

  initial begin
    tb_beat_t b;
    tb_beat_t e;
    int       cyc;

    // Hand-computed beat tables.
    a01_exp[0]  = '{areg: 5'd10, preg: 7'd40, data: 32'h0000_0037, last: 1'b0};
    a01_exp[1]  = '{areg: 5'd11, preg: 7'd41, data: 32'hFFFF_FFFE, last: 1'b1};
    wrap_exp[0] = '{areg: 5'd30, preg: 7'd62, data: 32'h1000_003E, last: 1'b0};
    wrap_exp[1] = '{areg: 5'd31, preg: 7'd63, data: 32'h1000_003F, last: 1'b0};
    wrap_exp[2] = '{areg: 5'd0,  preg: 7'd32, data: 32'h0000_0000, last: 1'b0};
    wrap_exp[3] = '{areg: 5'd1,  preg: 7'd33, data: 32'h1000_0021, last: 1'b1};

    // Request table: start, count, expected beats, expected final areg.
    vt[0] = '{start: 5'd10, count: 6'd2, nbeats: 2,  last_areg: 5'd11};
    vt[1] = '{start: 5'd30, count: 6'd4, nbeats: 4,  last_areg: 5'd1};
    vt[2] = '{start: 5'd0,  count: 6'd0, nbeats: 32, last_areg: 5'd31};
    vt[3] = '{start: 5'd31, count: 6'd2, nbeats: 2,  last_areg: 5'd0};
    vt[4] = '{start: 5'd7,  count: 6'd5, nbeats: 5,  last_areg: 5'd11};

    // Map areg i -> preg i+32, PRF[p] = 0x1000_0000 + p, plus specific entries.
    for (int i = 0; i < 32; i++) map_mem[i] = 7'(i + 32);
    for (int p = 0; p < 128; p++) prf_mem[p] = 32'h1000_0000 + 32'(p);
    prf_mem[32] = 32'hDEAD_BEEF;
    map_mem[10] = 7'd40; prf_mem[40] = 32'h0000_0037;
    map_mem[11] = 7'd41; prf_mem[41] = 32'hFFFF_FFFE;
    map_mem[20] = 7'd50;

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_start  = 5'd0;
    req_count  = 6'd0;
    map_stable = 1'b1;
    rsp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // a0/a1 dump with latency and beat spacing.
    send_req(5'd10, 6'd2);
    get_beat(b, cyc);
    chk("first_latency", 32'(cyc), 32'd3);
    chk_beat("a01[0]", b, a01_exp[0]);
    get_beat(b, cyc);
    chk("beat_spacing", 32'(cyc), 32'd3);
    chk_beat("a01[1]", b, a01_exp[1]);
    @(negedge clk);
    chk("a01_done_busy", 32'(busy), 32'd0);

    // Wrap with x0 reading zero despite PRF[map[0]] = 0xDEADBEEF.
    send_req(5'd30, 6'd4);
    for (int k = 0; k < 4; k++) begin
      get_beat(b, cyc);
      chk_beat($sformatf("wrap[%0d]", k), b, wrap_exp[k]);
    end

    // Table-driven requests checked against the map/PRF contents.
    for (int v = 0; v < 5; v++) begin
      send_req(vt[v].start, vt[v].count);
      for (int i = 0; i < vt[v].nbeats; i++) begin
        get_beat(b, cyc);
        e = model(vt[v].start + 5'(i), (i == vt[v].nbeats - 1));
        chk_beat($sformatf("vec%0d[%0d]", v, i), b, e);
        if (i == vt[v].nbeats - 1) begin
          chk($sformatf("vec%0d.final_areg", v), 32'(b.areg), 32'(vt[v].last_areg));
        end
      end
      @(negedge clk);
      chk($sformatf("vec%0d.no_extra", v), 32'(rsp_valid), 32'd0);
    end

    // Backpressure: hold beat 1 for 5 cycles.
    rsp_ready = 1'b0;
    send_req(5'd3, 6'd3);
    wait_valid(cyc);
    e = model(5'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      b.areg = rsp_areg; b.preg = rsp_preg; b.data = rsp_data; b.last = rsp_last;
      chk($sformatf("bp_hold%0d.valid", k), 32'(rsp_valid), 32'd1);
      chk_beat($sformatf("bp_hold%0d", k), b, e);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 3; i++) begin
      get_beat(b, cyc);
      chk_beat($sformatf("bp[%0d]", i), b, model(5'd3 + 5'(i), (i == 2)));
    end
    @(negedge clk);
    chk("bp.no_extra", 32'(rsp_valid), 32'd0);

    // Instability in PRF with a remap of areg 20 from preg 50 to 60.
    send_req(5'd20, 6'd1);
    @(negedge clk);
    @(negedge clk);
    map_stable  = 1'b0;
    map_mem[20] = 7'd60;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("unstable%0d.valid", k), 32'(rsp_valid), 32'd0);
    end
    map_stable = 1'b1;
    get_beat(b, cyc);
    chk_beat("unstable", b, '{areg: 5'd20, preg: 7'd60, data: 32'h1000_003C, last: 1'b1});

    // Reset during beat 3 of 8, then a single-register request.
    send_req(5'd0, 6'd8);
    get_beat(b, cyc);
    get_beat(b, cyc);
    wait_valid(cyc);
    reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");
    send_req(5'd5, 6'd1);
    get_beat(b, cyc);
    chk_beat("after_reset", b, '{areg: 5'd5, preg: 7'd37, data: 32'h1000_0025, last: 1'b1});

    // Request raised during the final handshake is taken in the next IDLE cycle.
    send_req(5'd12, 6'd1);
    wait_valid(cyc);
    req_valid = 1'b1;
    req_start = 5'd2;
    req_count = 6'd1;
    @(negedge clk);
    chk("late_req.busy_idle", 32'(busy), 32'd0);
    chk("late_req.ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("late_req.busy_after", 32'(busy), 32'd1);
    get_beat(b, cyc);
    chk_beat("late_req", b, '{areg: 5'd2, preg: 7'd34, data: 32'h1000_0022, last: 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/arch_reg_dump.md
# arch_reg_dump

Hardware responder that walks the committed rename map and physical register file and streams architectural register values out over a valid/ready channel. It sits beside the rename unit and PRF inside `processor`. It gives a bench, or a future debug port, a cycle-accurate architectural-state readout without hierarchical peeks into `rename_unit.map` or `PRF.phy_reg`. A requester asks for a contiguous range of architectural registers; the block returns one beat per register.

## Interface
- `ARCH_REGS`, 32, number of architectural registers (power of two)
- `PHYS_REGS`, 128, number of physical registers
- `DATA_W`, 32, register data width
- `AREG_W`, $clog2(ARCH_REGS), architectural index width
- `PREG_W`, $clog2(PHYS_REGS), physical index width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = in reset)
- `req_valid`  in  1  dump request
- `req_ready`  out  1  high only in IDLE
- `req_start`  in  AREG_W  first architectural register
- `req_count`  in  AREG_W+1  registers to dump; 0 means ARCH_REGS
- `map_stable`  in  1  rename map/PRF not being redirected (e.g. no mispredict recovery this cycle)
- `map_rd_areg`  out  AREG_W  combinational map read index
- `map_rd_preg`  in  PREG_W  map read result, same cycle
- `prf_rd_addr`  out  PREG_W  combinational PRF read index
- `prf_rd_data`  in  DATA_W  PRF read result, same cycle
- `rsp_valid`  out  1  response beat valid
- `rsp_ready`  in  1  consumer accepts beat
- `rsp_areg`  out  AREG_W  architectural index of beat
- `rsp_preg`  out  PREG_W  mapped physical register
- `rsp_data`  out  DATA_W  register value
- `rsp_last`  out  1  final beat of request
- `busy`  out  1  not IDLE

## Operation
- States: IDLE, MAP, PRF, OUT.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `cur`=`req_start` and `remain`=(`req_count`==0 ? ARCH_REGS : `req_count`).
  - Go to MAP.
- **MAP**
  - Drive `map_rd_areg`=`cur`.
  - If `map_stable`, register `preg_q`=`map_rd_preg` and go to PRF.
  - Otherwise stay in MAP and retry next cycle.
- **PRF**
  - Drive `prf_rd_addr`=`preg_q`.
  - If `map_stable`:
    - load `rsp_areg`=`cur`, `rsp_preg`=`preg_q`;
    - load `rsp_data`=(`cur`==0 ? 0 : `prf_rd_data`);
    - load `rsp_last`=(`remain`==1);
    - go to OUT.
  - If `map_stable` is low, return to MAP, because the mapping may have changed.
- **OUT**
  - `rsp_valid`=1. Response fields are held stable until `rsp_ready`.
  - On the handshake: if `rsp_last`, go to IDLE; else `cur`=`cur`+1 mod ARCH_REGS, `remain`-=1, go to MAP.
- Index wrap: `cur` wraps from ARCH_REGS-1 to 0 (AREG_W-bit natural overflow).
- x0 always reports data 0; `rsp_preg` still reports whatever the map holds.
- Requests are ignored while `busy`. There is no queuing.
- When not in MAP or PRF, the read indices drive the last value. They carry no side effects.

## Timing
- Reset values: `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_areg`=0, `rsp_preg`=0, `rsp_data`=0, `rsp_last`=0, `map_rd_areg`=0, `prf_rd_addr`=0. State is IDLE.
- With `map_stable`=1 and `rsp_ready`=1:
  - request accepted at edge N;
  - first `rsp_valid` visible after edge N+2;
  - one beat every 3 cycles after that.
- `rsp_valid` never drops without a handshake. A deasserted `map_stable` only delays beats that have not yet reached OUT.
- `rsp_ready` may be high before `rsp_valid`; only the cycle with both high counts.
- Reset asserted mid-dump: immediate return to IDLE with all outputs at reset values. The partial dump is discarded, with no `rsp_last`.
- `req_valid` during the final OUT handshake is not accepted; it is accepted in the following IDLE cycle.

## Structure
- Shared package `dump_pkg`:
  - state enum `dump_state_t` {IDLE, MAP, PRF, OUT};
  - typedef `dump_beat_t` with fields areg, preg, data, last.
- Single module. No sub-module is warranted.
- Output register set stored as one `dump_beat_t`.

## Test plan
- Dump a0/a1:
  - setup: map[10]=40 with PRF[40]=0x0000_0037; map[11]=41 with PRF[41]=0xFFFF_FFFE;
  - stimulus: start=10, count=2;
  - required: beats (10,40,0x37,last=0), then (11,41,0xFFFFFFFE,last=1), first `rsp_valid` 2 cycles after accept.
- Wrap: start=30, count=4 → areg sequence 30,31,0,1. The x0 beat has data 0 even if PRF[map[0]]=0xDEAD_BEEF. Only beat 1 has last=1.
- Full dump: count=0 → exactly 32 beats, areg 0..31, `rsp_last` only on areg 31.
- Backpressure: `rsp_ready` low for 5 cycles on beat 1 → fields stable and `rsp_valid` held; no beat lost or duplicated.
- Instability:
  - `map_stable` low for 3 cycles while in PRF, and map[20] is changed from 50 to 60 during that window;
  - required: the beat reports preg 60 with PRF[60] data.
- Reset mid-dump: assert `reset`=0 during beat 3 of 8 → all outputs zero and `req_ready`=1 after release. A new request for start=5, count=1 returns a single correct beat.
